// File: rtl/fetch_queue_if.sv
// Fetch queue bus bundle: instruction-cache request port, decode-side
// valid/ready head port, and the redirect/halt/occupancy control signals.
interface fetch_queue_if #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              ihit;
  logic [WORD_W-1:0] imemload;
  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;
  logic              redirect;
  logic [WORD_W-1:0] redirect_pc;
  logic              halt;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_instr;
  logic [WORD_W-1:0] out_pc;
  logic [WORD_W-1:0] out_npc;
  logic [CNT_W-1:0]  count;

  // The fetch queue is the master: it issues cache reads and drives the head.
  modport master (
    input  ihit, imemload, redirect, redirect_pc, halt, out_ready,
    output imemREN, imemaddr, out_valid, out_instr, out_pc, out_npc, count
  );

  modport slave (
    output ihit, imemload, redirect, redirect_pc, halt, out_ready,
    input  imemREN, imemaddr, out_valid, out_instr, out_pc, out_npc, count
  );
endinterface

// File: rtl/fetch_queue.sv
// PC owner and instruction prefetch FIFO: fetches sequential words into a
// DEPTH-entry queue, presents the head to decode, flushes on redirect.
module fetch_queue #(
  parameter int                WORD_W  = 32,
  parameter int                DEPTH   = 4,
  parameter logic [WORD_W-1:0] PC_INIT = '0
) (
  input  logic          CLK,
  input  logic          nRST,
  fetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 3 * WORD_W;

  logic [WORD_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [ENT_W-1:0]  entry_q [DEPTH];
  logic [ENT_W-1:0]  entry_d [DEPTH];

  logic              full;
  logic              req;
  logic              push;
  logic              pop;
  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] redirect_target;
  logic [ENT_W-1:0]  head;

  assign full            = (count_q == CNT_W'(DEPTH));
  // Full blocks the request even when the head is popped in the same cycle.
  assign req             = nRST && !bus.halt && !bus.redirect && !full;
  assign push            = req && bus.ihit;
  assign pop             = (count_q != '0) && bus.out_ready;
  assign pc_plus4        = pc_q + WORD_W'(4);
  assign redirect_target = bus.redirect_pc & ~WORD_W'(3);

  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.redirect) begin
      pc_d     = redirect_target;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        pc_d     = pc_plus4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q     <= PC_INIT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; contents are only meaningful while counted.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_comb begin
        entry_d[gi] = entry_q[gi];
        if (push && (wr_ptr_q == PTR_W'(gi))) begin
          entry_d[gi] = {bus.imemload, pc_q, pc_plus4};
        end
      end

      always_ff @(posedge CLK) begin
        entry_q[gi] <= entry_d[gi];
      end
    end
  endgenerate

  assign head          = entry_q[rd_ptr_q];
  assign bus.imemREN   = req;
  assign bus.imemaddr  = pc_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_instr = head[3*WORD_W-1:2*WORD_W];
  assign bus.out_pc    = head[2*WORD_W-1:WORD_W];
  assign bus.out_npc   = head[WORD_W-1:0];
  assign bus.count     = count_q;
endmodule
